// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file with clear sequencer
//
// Two prioritised write ports (port 1 wins on address collision), NUM_RD
// independent read ports with optional write-to-read bypass, optional
// registered read and optional hardwired-zero entry 0. A clear request
// sweeps every entry to zero, one entry per cycle, without a global reset.
//
// Ports:
//   clk       core clock, rising edge
//   reset     asynchronous, active-high
//   rd_addr   NUM_RD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD read data words, port k at [k*DATA_W +: DATA_W]
//   wr_en     write enables for write ports 0 and 1
//   wr_addr   write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wr_data   write data, port j at [j*DATA_W +: DATA_W]
//   clr_req   single-cycle request to start a clear sweep
//   clr_busy  high while the sweep runs
//   clr_done  single-cycle pulse when the sweep completes
module reg_file_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 7,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                idle;
    logic [ADDR_W-1:0]   wa0;
    logic [ADDR_W-1:0]   wa1;
    logic [DATA_W-1:0]   wd0;
    logic [DATA_W-1:0]   wd1;
    logic [1:0]          wr_act;

    assign idle = (state == ST_IDLE);
    assign wa0  = wr_addr[0 +: ADDR_W];
    assign wa1  = wr_addr[ADDR_W +: ADDR_W];
    assign wd0  = wr_data[0 +: DATA_W];
    assign wd1  = wr_data[DATA_W +: DATA_W];

    // A write takes effect only in IDLE; with a hardwired-zero entry 0 any
    // write aimed at it is dropped here so neither the array nor the bypass
    // path ever sees it.
    always_comb begin
        wr_act    = '0;
        wr_act[0] = idle && wr_en[0] && !((ZERO_R0 != 0) && (wa0 == '0));
        wr_act[1] = idle && wr_en[1] && !((ZERO_R0 != 0) && (wa1 == '0));
    end

    // Clear sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear sequencer next-state and outputs
    always_comb begin
        state_next = state;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                clr_busy = 1'b1;
                if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sweep counter: wraps to 0 after the last entry, and is held at 0
    // outside the sweep so the next sweep always starts at entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (state == ST_SWEEP) begin
            sweep_cnt <= sweep_cnt + ADDR_W'(1);
        end else begin
            sweep_cnt <= '0;
        end
    end

    // Storage array. Port 1 is written after port 0 so it wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (state == ST_SWEEP) begin
                mem[sweep_cnt] <= '0;
            end
            if (wr_act[0]) begin
                mem[wa0] <= wd0;
            end
            if (wr_act[1]) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Read ports
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // wr_act already carries the IDLE qualification, so bypass is
        // naturally off during SWEEP and DONE.
        always_comb begin
            val = mem[ra];
            if (BYPASS != 0) begin
                if (wr_act[0] && (wa0 == ra)) begin
                    val = wd0;
                end
                if (wr_act[1] && (wa1 == ra)) begin
                    val = wd1;
                end
            end
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                val = '0;
            end
        end

        if (READ_LAT == 0) begin : g_comb
            assign rd_data[k*DATA_W +: DATA_W] = val;
        end else begin : g_reg
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= val;
                end
            end
            assign rd_data[k*DATA_W +: DATA_W] = q;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (default and latency-1/zero-r0/no-bypass builds)
module tb_reg_file_mp;

    localparam int DW    = 64;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic            clk;
    logic            reset;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            clr_req;

    logic [2*DW-1:0] rd_data_a;
    logic            clr_busy_a;
    logic            clr_done_a;
    logic [2*DW-1:0] rd_data_b;
    logic            clr_busy_b;
    logic            clr_done_b;

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2),
        .READ_LAT(0), .BYPASS(1), .ZERO_R0(0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2),
        .READ_LAT(1), .BYPASS(0), .ZERO_R0(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus of the current cycle
    logic [AW-1:0] ra [2];
    logic [AW-1:0] wa [2];
    logic [DW-1:0] wd [2];
    logic [1:0]    we;
    logic          cr;

    // reference contents for each build, and sweep progress (0 = idle,
    // DEPTH+1..2 = sweep cycles, 1 = done cycle)
    logic [DW-1:0] ma [DEPTH];
    logic [DW-1:0] mb [DEPTH];
    int            sweep_left;

    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic models_zero();
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        we = 2'b00;
        cr = 1'b0;
        wa[0] = '0; wa[1] = '0;
        wd[0] = '0; wd[1] = '0;
    endtask

    // One clock cycle: drive, predict, compare at negedge, update the model
    // after the rising edge.
    task automatic tick();
        logic [DW-1:0] e;
        rd_addr = {ra[1], ra[0]};
        wr_en   = we;
        wr_addr = {wa[1], wa[0]};
        wr_data = {wd[1], wd[0]};
        clr_req = cr;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = ma[ra[k]];
            if (sweep_left == 0) begin
                if (we[0] && wa[0] == ra[k]) e = wd[0];
                if (we[1] && wa[1] == ra[k]) e = wd[1];
            end
            qa.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            check("rd_a", rd_data_a[k*DW +: DW], qa.pop_front());
        end
        if (qb.size() >= 2) begin
            for (int k = 0; k < 2; k++) begin
                check("rd_b", rd_data_b[k*DW +: DW], qb.pop_front());
            end
        end
        for (int k = 0; k < 2; k++) begin
            qb.push_back((ra[k] == '0) ? 64'd0 : mb[ra[k]]);
        end
        check("busy_a", {63'd0, clr_busy_a}, {63'd0, sweep_left >= 2});
        check("done_a", {63'd0, clr_done_a}, {63'd0, sweep_left == 1});
        check("busy_b", {63'd0, clr_busy_b}, {63'd0, sweep_left >= 2});
        check("done_b", {63'd0, clr_done_b}, {63'd0, sweep_left == 1});
        @(posedge clk);
        #1;
        if (sweep_left == 0) begin
            for (int j = 0; j < 2; j++) begin
                if (we[j]) begin
                    ma[wa[j]] = wd[j];
                    if (wa[j] != '0) mb[wa[j]] = wd[j];
                end
            end
            if (cr) sweep_left = DEPTH + 1;
        end else begin
            if (sweep_left >= 2) begin
                ma[DEPTH + 1 - sweep_left] = '0;
                mb[DEPTH + 1 - sweep_left] = '0;
            end
            sweep_left--;
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH / 2; i++) begin
            ra[0] = AW'(2 * i);
            ra[1] = AW'(2 * i + 1);
            tick();
        end
    endtask

    task automatic rand_tick();
        ra[0] = AW'($urandom_range(0, DEPTH - 1));
        ra[1] = AW'($urandom_range(0, DEPTH - 1));
        we    = 2'($urandom_range(0, 3));
        wa[0] = ($urandom_range(0, 3) == 0) ? ra[0] : AW'($urandom_range(0, DEPTH - 1));
        wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : AW'($urandom_range(0, DEPTH - 1));
        wd[0] = {$urandom, $urandom};
        wd[1] = {$urandom, $urandom};
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        ra[0] = '0; ra[1] = '0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
        sweep_left = 0;
        models_zero();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_b0", rd_data_b[0 +: DW], 64'd0);
        check("rst_rd_b1", rd_data_b[DW +: DW], 64'd0);
        check("rst_busy", {63'd0, clr_busy_a}, 64'd0);
        check("rst_done", {63'd0, clr_done_a}, 64'd0);
        reset = 1'b0;

        read_all();

        // port 0 write to 5, same-cycle read of 5 and 6
        we = 2'b01; wa[0] = 7'd5; wd[0] = 64'h0123_4567_89AB_CDEF;
        ra[0] = 7'd6; ra[1] = 7'd5;
        tick();
        ra[0] = 7'd6; ra[1] = 7'd5;
        tick();

        // collision on 9: port 1 wins
        we = 2'b11; wa[0] = 7'd9; wa[1] = 7'd9; wd[0] = 64'hAAAA; wd[1] = 64'h5555;
        ra[0] = 7'd9; ra[1] = 7'd9;
        tick();
        ra[0] = 7'd9; ra[1] = 7'd5;
        tick();

        // write to entry 0 (discarded by the zero-r0 build)
        we = 2'b10; wa[1] = 7'd0; wd[1] = 64'hFFFF;
        ra[0] = 7'd0; ra[1] = 7'd0;
        tick();
        ra[0] = 7'd0; ra[1] = 7'd9;
        tick();

        repeat (40) rand_tick();

        // fill every entry with its index
        for (int i = 0; i < DEPTH / 2; i++) begin
            we = 2'b11;
            wa[0] = AW'(2 * i);     wd[0] = DW'(2 * i);
            wa[1] = AW'(2 * i + 1); wd[1] = DW'(2 * i + 1);
            ra[0] = AW'($urandom_range(0, DEPTH - 1));
            ra[1] = AW'(2 * i);
            tick();
        end
        read_all();

        // clear request together with a write: the write lands, then is swept
        cr = 1'b1; we = 2'b01; wa[0] = 7'd7; wd[0] = 64'h77;
        ra[0] = 7'd7; ra[1] = 7'd3;
        tick();
        for (int c = 0; c < DEPTH + 1; c++) begin
            ra[0] = 7'd3;
            ra[1] = AW'($urandom_range(0, DEPTH - 1));
            if (c == 5) begin
                we = 2'b01; wa[0] = 7'd3; wd[0] = 64'hDEAD;
            end
            if (c == 20 || c == DEPTH) cr = 1'b1;
            tick();
        end
        read_all();

        // reset in the middle of a sweep
        repeat (10) rand_tick();
        cr = 1'b1;
        tick();
        repeat (40) rand_tick();
        reset = 1'b1;
        #1;
        check("mid_busy_a", {63'd0, clr_busy_a}, 64'd0);
        check("mid_done_a", {63'd0, clr_done_a}, 64'd0);
        check("mid_busy_b", {63'd0, clr_busy_b}, 64'd0);
        check("mid_rd_b0", rd_data_b[0 +: DW], 64'd0);
        models_zero();
        sweep_left = 0;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        read_all();

        we = 2'b01; wa[0] = 7'd10; wd[0] = 64'hCAFE_F00D_1234_5678;
        ra[0] = 7'd10; ra[1] = 7'd11;
        tick();
        ra[0] = 7'd11; ra[1] = 7'd10;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
